// File: rtl/suma.sv
// suma: captures one operand from each of two counter-fed sources, adds them
// modulo 256 and holds the sum until the downstream divider accepts it.
module suma #(
    parameter logic [7:0] A_INIT = 8'd1,
    parameter logic [7:0] B_INIT = 8'd2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       validoA,
    input  logic       validoB,
    input  logic       divisionLista,
    output logic [7:0] salida,
    output logic       ListoS,
    output logic       ListoA,
    output logic       ListoB
);
    typedef enum logic [1:0] {IDLE, CAPTURE, ADD, OUT} state_t;
    state_t state, state_n;
    logic [7:0] cnt_a, cnt_b, op_a, op_b;
    logic got_a, got_b, take_a, take_b, do_add, release_s;

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;

    // The edge that latches the second operand also leaves CAPTURE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = CAPTURE;
            CAPTURE: state_n = ((got_a || take_a) && (got_b || take_b)) ? ADD : CAPTURE;
            ADD:     state_n = OUT;
            OUT:     state_n = divisionLista ? CAPTURE : OUT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        take_a    = (state == CAPTURE) && validoA && !got_a;
        take_b    = (state == CAPTURE) && validoB && !got_b;
        do_add    = state == ADD;
        release_s = (state == OUT) && divisionLista;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_a  <= A_INIT;
            cnt_b  <= B_INIT;
            op_a   <= 8'd0;
            op_b   <= 8'd0;
            got_a  <= 1'b0;
            got_b  <= 1'b0;
            salida <= 8'd0;
            ListoS <= 1'b0;
            ListoA <= 1'b0;
            ListoB <= 1'b0;
        end else begin
            ListoA <= take_a;
            ListoB <= take_b;
            if (take_a) begin
                op_a  <= cnt_a;
                cnt_a <= cnt_a + 8'd1;
            end
            if (take_b) begin
                op_b  <= cnt_b;
                cnt_b <= cnt_b + 8'd1;
            end
            got_a <= release_s ? 1'b0 : (got_a || take_a);
            got_b <= release_s ? 1'b0 : (got_b || take_b);
            if (do_add) begin
                salida <= op_a + op_b;
                ListoS <= 1'b1;
            end else if (release_s) begin
                ListoS <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_suma.sv
// tb_suma: directed scenarios plus random traffic for suma, each cycle
// compared against a behavioural model of the capture/add/present sequence.
module tb_suma;
    logic clock = 1'b0, reset = 1'b1, validoA = 1'b0, validoB = 1'b0, divisionLista = 1'b0;
    logic [7:0] salida;
    logic ListoS, ListoA, ListoB;
    int vectors = 0, miscompares = 0;

    suma dut (
        .clock(clock), .reset(reset), .validoA(validoA), .validoB(validoB),
        .divisionLista(divisionLista), .salida(salida), .ListoS(ListoS),
        .ListoA(ListoA), .ListoB(ListoB)
    );

    always #5 clock = ~clock;

    localparam int WAITING = 0, COLLECTING = 1, SUMMING = 2, PRESENTING = 3;
    int m_phase, m_next_a, m_next_b, m_a, m_b, m_sum;
    bit m_have_a, m_have_b, m_ls, m_la, m_lb, prev_la, prev_lb, prev_ls, ls_rise;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_phase = WAITING; m_have_a = 0; m_have_b = 0;
            m_next_a = 1; m_next_b = 2; m_a = 0; m_b = 0; m_sum = 0;
            m_ls = 0; m_la = 0; m_lb = 0;
        end else begin
            m_la = 0; m_lb = 0;
            if (m_phase == WAITING) m_phase = COLLECTING;
            else if (m_phase == COLLECTING) begin
                if (validoA && !m_have_a) begin
                    m_a = m_next_a; m_next_a = (m_next_a + 1) % 256; m_have_a = 1; m_la = 1;
                end
                if (validoB && !m_have_b) begin
                    m_b = m_next_b; m_next_b = (m_next_b + 1) % 256; m_have_b = 1; m_lb = 1;
                end
                if (m_have_a && m_have_b) m_phase = SUMMING;
            end else if (m_phase == SUMMING) begin
                m_sum = (m_a + m_b) % 256; m_ls = 1; m_phase = PRESENTING;
            end else if (divisionLista) begin
                m_ls = 0; m_have_a = 0; m_have_b = 0; m_phase = COLLECTING;
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("salida", salida, m_sum);
        check("ListoS", ListoS, m_ls);
        check("ListoA", ListoA, m_la);
        check("ListoB", ListoB, m_lb);
        check("ListoA_twice", ListoA && prev_la, 0);
        check("ListoB_twice", ListoB && prev_lb, 0);
        ls_rise = ListoS && !prev_ls;
        prev_la = ListoA; prev_lb = ListoB; prev_ls = ListoS;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int pulses, k, ta, tb, ts, n;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            validoA = 1'($urandom_range(0, 1));
            validoB = 1'($urandom_range(0, 1));
            divisionLista = 1'($urandom_range(0, 1));
            step();
        end
        reset = 1'b0; validoA = 1'b1; validoB = 1'b1; divisionLista = 1'b0;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            pulses += int'(ListoA && ListoB);
        end
        check("single_pulse", pulses, 1);
        check("held_sum", salida, 3);
        check("held_ListoS", ListoS, 1);
        divisionLista = 1'b1;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (ls_rise) begin
                check("repeat_sum", salida, 5 + 2 * k);
                k++;
            end
        end
        check("repeat_count", k, 3);

        do_reset();
        validoA = 1'b1; validoB = 1'b0; divisionLista = 1'b0;
        ta = -1; tb = -1; ts = -1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) validoB = 1'b1;
            step();
            if (ListoA && ta < 0) ta = c;
            if (ListoB && tb < 0) tb = c;
            if (ListoS && ts < 0) ts = c;
        end
        check("b_after_a", tb > ta && ta >= 0, 1);
        check("sum_one_after_b", ts - tb, 1);
        check("staggered_sum", salida, 3);

        do_reset();
        validoA = 1'b1; validoB = 1'b1; divisionLista = 1'b1;
        n = 0;
        for (int c = 0; c < 500 && n < 128; c++) begin
            step();
            if (ls_rise) begin
                n++;
                if (n == 127) check("sum_127", salida, 255);
                if (n == 128) check("sum_wrap", salida, 1);
            end
        end
        check("wrap_reached", n, 128);

        do_reset();
        divisionLista = 1'b0;
        repeat (5) step();
        check("out_before_reset", ListoS, 1);
        do_reset();
        check("abort_ListoS", ListoS, 0);
        check("abort_salida", salida, 0);
        repeat (4) step();
        check("after_abort_sum", salida, 3);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            validoA = ($urandom_range(0, 3) != 0);
            validoB = ($urandom_range(0, 2) == 0);
            divisionLista = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
